muldiv_sequencer: RTL and testbench

- Iterative signed multiply/divide unit plus its sequencer. It serves the MULT and DIV R-type instructions.
- The main control unit pulses start with the operands from regs A/B. It then waits on busy/done.
- On completion the block drives the HI/LO values and a one-cycle hilo_write strobe. It also reports divide-by-zero so the control unit can raise the exception.

---
 rtl/muldiv_pkg.sv | 31 +++
 rtl/muldiv_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative signed multiply/divide sequencer.
// The early-termination option is selected with the MULDIV_EARLY_TERM_EN macro in muldiv_sequencer.
package muldiv_pkg;

   localparam int unsigned MD_WIDTH = 32;
   localparam int unsigned CNT_W    = $clog2(MD_WIDTH) + 1;

   typedef enum logic {
      OP_MULT = 1'b0,
      OP_DIV  = 1'b1
   } op_e;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PREP = 3'd1,
      ITER = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } state_e;

   // Two's-complement negation
   function automatic logic [MD_WIDTH-1:0] neg2c(input logic [MD_WIDTH-1:0] x);
      return ~x + {{(MD_WIDTH-1){1'b0}}, 1'b1};
   endfunction

   // Unsigned magnitude; the most negative value maps onto itself as unsigned
   function automatic logic [MD_WIDTH-1:0] abs_u(input logic [MD_WIDTH-1:0] x);
      return x[MD_WIDTH-1] ? neg2c(x) : x;
   endfunction

endpackage

// File: rtl/muldiv_sequencer.sv
// Iterative signed MULT/DIV unit with its sequencer; results land in HI/LO.
// Optional macro MULDIV_EARLY_TERM_EN: MULT stops iterating once the remaining multiplier is zero.
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = MD_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic             hilo_write,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   state_e               state_q, state_d;
   op_e                  op_q, op_d;
   logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0]     mag_b_q, mag_b_d;
   logic [WIDTH-1:0]     shreg_q, shreg_d;   // multiplier (MULT) or dividend/quotient (DIV)
   logic [WIDTH-1:0]     rem_q, rem_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d, mcand_q, mcand_d;
   logic                 sign_a_q, sign_a_d, sign_b_q, sign_b_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
   logic                 busy_q, busy_d, done_q, done_d;
   logic                 div_zero_q, div_zero_d, hilo_write_q, hilo_write_d;

   logic                 iter_last;
   logic [WIDTH:0]       rem_sh, rem_sub;
   logic                 rem_ge;

   // Iteration exit condition
   always_comb begin
`ifdef MULDIV_EARLY_TERM_EN
      if ((op_q == OP_MULT) && (shreg_q[WIDTH-1:1] == {(WIDTH-1){1'b0}})) begin
         iter_last = 1'b1;
      end else begin
         iter_last = (cnt_q == LAST_ITER);
      end
`else
      iter_last = (cnt_q == LAST_ITER);
`endif
   end

   // Next state and registered-output next values
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) state_d = PREP;
            else       state_d = IDLE;
         end
         PREP: begin
            if ((op_q == OP_DIV) && (b_q == {WIDTH{1'b0}})) state_d = DONE;
            else                                            state_d = ITER;
         end
         ITER: begin
            if (iter_last) state_d = FIX;
            else           state_d = ITER;
         end
         FIX:     state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d       = (state_d != IDLE);
      done_d       = (state_d == DONE);
      div_zero_d   = (state_q == PREP) && (state_d == DONE);
      hilo_write_d = (state_q == FIX);
   end

   // Datapath: operand capture, shift-add / restoring-divide step, sign fix-up
   always_comb begin
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      mag_b_d  = mag_b_q;
      shreg_d  = shreg_q;
      rem_d    = rem_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      sign_a_d = sign_a_q;
      sign_b_d = sign_b_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      rem_sh   = {rem_q, shreg_q[WIDTH-1]};
      rem_sub  = rem_sh - {1'b0, mag_b_q};
      rem_ge   = ~rem_sub[WIDTH];
      case (state_q)
         IDLE: begin
            if (start) begin
               op_d = op_e'(op);
               a_d  = a;
               b_d  = b;
            end else begin
               op_d = op_q;
            end
         end
         PREP: begin
            sign_a_d = a_q[WIDTH-1];
            sign_b_d = b_q[WIDTH-1];
            mag_b_d  = abs_u(b_q);
            acc_d    = {(2*WIDTH){1'b0}};
            mcand_d  = {{WIDTH{1'b0}}, abs_u(a_q)};
            rem_d    = {WIDTH{1'b0}};
            cnt_d    = {CNT_W{1'b0}};
            if (op_q == OP_MULT) shreg_d = abs_u(b_q);
            else                 shreg_d = abs_u(a_q);
         end
         ITER: begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (op_q == OP_MULT) begin
               if (shreg_q[0]) acc_d = acc_q + mcand_q;
               else            acc_d = acc_q;
               mcand_d = {mcand_q[2*WIDTH-2:0], 1'b0};
               shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            end else begin
               if (rem_ge) rem_d = rem_sub[WIDTH-1:0];
               else        rem_d = rem_sh[WIDTH-1:0];
               shreg_d = {shreg_q[WIDTH-2:0], rem_ge};
            end
         end
         FIX: begin
            if (op_q == OP_MULT) begin
               if (sign_a_q != sign_b_q) begin
                  // 64-bit negate from two halves: the low-half borrow decides the high half
                  lo_d = neg2c(acc_q[WIDTH-1:0]);
                  if (acc_q[WIDTH-1:0] == {WIDTH{1'b0}}) hi_d = neg2c(acc_q[2*WIDTH-1:WIDTH]);
                  else                                   hi_d = ~acc_q[2*WIDTH-1:WIDTH];
               end else begin
                  lo_d = acc_q[WIDTH-1:0];
                  hi_d = acc_q[2*WIDTH-1:WIDTH];
               end
            end else begin
               if (sign_a_q != sign_b_q) lo_d = neg2c(shreg_q);
               else                      lo_d = shreg_q;
               if (sign_a_q) hi_d = neg2c(rem_q);
               else          hi_d = rem_q;
            end
         end
         DONE:    cnt_d = cnt_q;
         default: cnt_d = cnt_q;
      endcase
   end

   // State, datapath and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         op_q         <= OP_MULT;
         a_q          <= {WIDTH{1'b0}};
         b_q          <= {WIDTH{1'b0}};
         mag_b_q      <= {WIDTH{1'b0}};
         shreg_q      <= {WIDTH{1'b0}};
         rem_q        <= {WIDTH{1'b0}};
         acc_q        <= {(2*WIDTH){1'b0}};
         mcand_q      <= {(2*WIDTH){1'b0}};
         sign_a_q     <= 1'b0;
         sign_b_q     <= 1'b0;
         cnt_q        <= {CNT_W{1'b0}};
         hi_q         <= {WIDTH{1'b0}};
         lo_q         <= {WIDTH{1'b0}};
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         div_zero_q   <= 1'b0;
         hilo_write_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         a_q          <= a_d;
         b_q          <= b_d;
         mag_b_q      <= mag_b_d;
         shreg_q      <= shreg_d;
         rem_q        <= rem_d;
         acc_q        <= acc_d;
         mcand_q      <= mcand_d;
         sign_a_q     <= sign_a_d;
         sign_b_q     <= sign_b_d;
         cnt_q        <= cnt_d;
         hi_q         <= hi_d;
         lo_q         <= lo_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         div_zero_q   <= div_zero_d;
         hilo_write_q <= hilo_write_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign div_zero   = div_zero_q;
   assign hilo_write = hilo_write_q;
   assign hi         = hi_q;
   assign lo         = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer (build with or without MULDIV_EARLY_TERM_EN).
module tb_muldiv_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        op = 1'b0;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic        busy, done, div_zero, hilo_write;
   logic [31:0] hi, lo;

   int   errors = 0;
   int   checks = 0;
   int   lat;
   logic dz_at, hw_at, busy_gap, done_after, busy_after;
   int   done_cnt, done_cyc;
   logic late_busy, seen_done;

   muldiv_sequencer #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .div_zero(div_zero), .hilo_write(hilo_write),
      .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected done cycle of a MULT, given the multiplier operand
   function automatic int mult_lat(input logic [31:0] bv);
      logic [31:0] m;
      int          n;
      m = bv[31] ? (~bv + 32'd1) : bv;
      n = 0;
      for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
      if (n < 1) n = 1;
`ifdef MULDIV_EARLY_TERM_EN
      return 3 + n;
`else
      return (n > 0) ? 35 : 35;
`endif
   endfunction

   // Start one operation in cycle 0 and wait (bounded) for its done pulse
   task automatic run_op(input logic o, input logic [31:0] av, input logic [31:0] bv);
      op = o; a = av; b = bv; start = 1'b1;
      step();
      start = 1'b0;
      lat = -1; busy_gap = 1'b0; dz_at = 1'b0; hw_at = 1'b0;
      for (int c = 1; c <= 60; c++) begin
         if (!busy) busy_gap = 1'b1;
         if (done) begin
            lat = c; dz_at = div_zero; hw_at = hilo_write;
            break;
         end
         step();
      end
      step();
      done_after = done; busy_after = busy;
   endtask

   initial begin
      reset = 1'b1;
      repeat (3) step();
      reset = 1'b0;
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_flags", {62'd0, div_zero, hilo_write}, 64'd0);
      chk("rst_hilo", {hi, lo}, 64'd0);

      // MULT 7 * -3
      run_op(1'b0, 32'd7, 32'hFFFF_FFFD);
      chk("t1_lat", 64'(lat), 64'(mult_lat(32'hFFFF_FFFD)));
      chk("t1_busy_gap", {63'd0, busy_gap}, 64'd0);
      chk("t1_flags", {62'd0, dz_at, hw_at}, 64'd1);
      chk("t1_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
      chk("t1_single_done", {62'd0, done_after, busy_after}, 64'd0);

      // DIV by zero keeps the previous HI/LO
      run_op(1'b1, 32'd5, 32'd0);
      chk("t3_lat", 64'(lat), 64'd2);
      chk("t3_flags", {62'd0, dz_at, hw_at}, 64'd2);
      chk("t3_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
      chk("t3_single_done", {62'd0, done_after, div_zero}, 64'd0);

      // MULT most-negative squared
      run_op(1'b0, 32'h8000_0000, 32'h8000_0000);
      chk("t2m_lat", 64'(lat), 64'(mult_lat(32'h8000_0000)));
      chk("t2m_hilo", {hi, lo}, 64'h4000_0000_0000_0000);

      // DIV -7 / 2
      run_op(1'b1, 32'hFFFF_FFF9, 32'd2);
      chk("t2d_lat", 64'(lat), 64'd35);
      chk("t2d_flags", {62'd0, dz_at, hw_at}, 64'd1);
      chk("t2d_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

      // DIV 100 / -7
      run_op(1'b1, 32'd100, 32'hFFFF_FFF9);
      chk("div_pos_neg", {hi, lo}, 64'h0000_0002_FFFF_FFF2);

      // DIV -2^31 / -1
      run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      chk("t4_flags", {62'd0, dz_at, hw_at}, 64'd1);
      chk("t4_hilo", {hi, lo}, 64'h0000_0000_8000_0000);

      // MULT 3 * 5 (latency depends on build)
      run_op(1'b0, 32'd3, 32'd5);
      chk("t6_lat", 64'(lat), 64'(mult_lat(32'd5)));
      chk("t6_hilo", {hi, lo}, 64'd15);

      // Extra start pulses in cycles 5 and 35 are ignored
      op = 1'b0; a = 32'd3; b = 32'h8000_0000; start = 1'b1;
      step();
      op = 1'b1; a = 32'd1; b = 32'd1;
      done_cnt = 0; done_cyc = -1; late_busy = 1'b0;
      for (int c = 1; c <= 37; c++) begin
         if (done) begin
            done_cnt++;
            done_cyc = c;
         end
         if (c >= 36 && busy) late_busy = 1'b1;
         start = (c == 5) || (c == 35);
         step();
      end
      start = 1'b0;
      chk("t5_done_cnt", 64'(done_cnt), 64'd1);
      chk("t5_done_cyc", 64'(done_cyc), 64'd35);
      chk("t5_late_busy", {63'd0, late_busy}, 64'd0);
      chk("t5_hilo", {hi, lo}, 64'hFFFF_FFFE_8000_0000);

      // Reset in cycle 10 aborts the operation
      op = 1'b0; a = 32'd7; b = 32'hFFFF_FFFD; start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 2; c <= 10; c++) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("t5r_busy", {62'd0, busy, done}, 64'd0);
      chk("t5r_hilo", {hi, lo}, 64'd0);
      seen_done = 1'b0;
      for (int c = 11; c <= 40; c++) begin
         if (done || busy) seen_done = 1'b1;
         step();
      end
      chk("t5r_no_done", {63'd0, seen_done}, 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
